button_updown_counter: RTL and testbench



---
 rtl/button_updown_counter.sv | 265 ++++++++++++++++++++++++++
 tb/tb_button_updown_counter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/button_updown_counter.sv
// Debounced two-button up/down counter with wrap or saturate arithmetic.
// Define BUTTON_COUNTER_AUTO_REPEAT_EN for auto-repeat while a button is held.
module button_updown_counter_db #(
  parameter int DEBOUNCE_CYCLES = 4
`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
  ,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4
`endif
) (
  input  logic clk,
  input  logic reset,
  input  logic i_pin,
  output logic o_req
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LP_DB = CW'(DEBOUNCE_CYCLES);

  typedef enum logic [1:0] {
    S_RELEASED,
    S_PRESS_WAIT,
    S_HELD,
    S_RELEASE_WAIT
  } state_t;

  logic          r_meta;
  logic          r_sync;
  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt;
  logic          r_req;
  logic          w_req;
  logic          w_press;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= i_pin;
      r_sync <= r_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_RELEASED;
      r_cnt   <= '0;
      r_req   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt;
      r_req   <= w_req;
    end
  end

  // A full count wins over the current sample, so a pulse of exactly
  // DEBOUNCE_CYCLES samples is still accepted.
  always_comb begin
    w_next = r_state;
    w_cnt  = r_cnt;
    unique case (r_state)
      S_RELEASED: begin
        if (r_sync) begin
          w_next = S_PRESS_WAIT;
          w_cnt  = CW'(1);
        end
      end
      S_PRESS_WAIT: begin
        if (r_cnt == LP_DB) begin
          w_next = S_HELD;
          w_cnt  = '0;
        end else if (!r_sync) begin
          w_next = S_RELEASED;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      S_HELD: begin
        if (!r_sync) begin
          w_next = S_RELEASE_WAIT;
          w_cnt  = CW'(1);
        end
      end
      S_RELEASE_WAIT: begin
        if (r_cnt == LP_DB) begin
          w_next = S_RELEASED;
          w_cnt  = '0;
        end else if (r_sync) begin
          w_next = S_HELD;
          w_cnt  = '0;
        end else begin
          w_cnt = r_cnt + CW'(1);
        end
      end
      default: begin
        w_next = S_RELEASED;
        w_cnt  = '0;
      end
    endcase
  end

  assign w_press = (r_state == S_PRESS_WAIT) && (r_cnt == LP_DB);

`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
  localparam int LP_RMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int RW = $clog2(LP_RMAX + 1);
  localparam logic [RW-1:0] LP_HOLD = RW'(HOLD_CYCLES);
  localparam logic [RW-1:0] LP_REP  = RW'(REPEAT_CYCLES);

  logic [RW-1:0] r_rep;
  logic          r_rpt;
  logic          w_active;
  logic          w_fire;

  assign w_active = (r_state == S_HELD) ||
                    (r_state == S_RELEASE_WAIT);

  // r_rep holds the cycles elapsed since the last request edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rep <= '0;
      r_rpt <= 1'b0;
    end else if (w_press) begin
      r_rep <= RW'(1);
      r_rpt <= 1'b0;
    end else if (w_active) begin
      if (w_fire) begin
        r_rep <= RW'(1);
        r_rpt <= 1'b1;
      end else begin
        r_rep <= r_rep + RW'(1);
      end
    end else begin
      r_rep <= '0;
      r_rpt <= 1'b0;
    end
  end

  always_comb begin
    w_fire = w_active &&
             (w_next != S_RELEASED) &&
             (r_rep == (r_rpt ? LP_REP : LP_HOLD));
    w_req  = w_press | w_fire;
  end
`else
  always_comb begin
    w_req = w_press;
  end
`endif

  assign o_req = r_req;

endmodule

module button_updown_counter #(
  parameter int WIDTH           = 8,
  parameter int STEP            = 1,
  parameter int MODE            = 0,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int RESET_VALUE     = 0,
  parameter int HOLD_CYCLES     = 8,
  parameter int REPEAT_CYCLES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             east,
  input  logic             west,
  output logic [WIDTH-1:0] led,
  output logic             overflow
);

  if (WIDTH < 2 || WIDTH > 16 || STEP < 1 ||
      MODE < 0 || MODE > 1 || DEBOUNCE_CYCLES < 2 ||
      HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_bad_param
    $error("button_updown_counter: illegal parameter");
  end

  localparam logic [WIDTH:0] LP_STEP = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] LP_RST = WIDTH'(RESET_VALUE);

  logic             w_req_e;
  logic             w_req_w;
  logic             w_up;
  logic             w_dn;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH:0]   w_dif;
  logic [WIDTH-1:0] w_led;
  logic             w_ovf;
  logic [WIDTH-1:0] r_led;
  logic             r_ovf;

  button_updown_counter_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
    ,
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_db_east (
    .clk   (clk),
    .reset (reset),
    .i_pin (east),
    .o_req (w_req_e)
  );

  button_updown_counter_db #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
    ,
    .HOLD_CYCLES     (HOLD_CYCLES),
    .REPEAT_CYCLES   (REPEAT_CYCLES)
`endif
  ) u_db_west (
    .clk   (clk),
    .reset (reset),
    .i_pin (west),
    .o_req (w_req_w)
  );

  // Coincident requests cancel each other.
  assign w_up  = w_req_e & ~w_req_w;
  assign w_dn  = w_req_w & ~w_req_e;
  assign w_sum = {1'b0, r_led} + LP_STEP;
  assign w_dif = {1'b0, r_led} - LP_STEP;

  always_comb begin
    w_led = r_led;
    w_ovf = 1'b0;
    unique case (1'b1)
      w_up: begin
        w_ovf = w_sum[WIDTH];
        w_led = (w_sum[WIDTH] && MODE == 1) ?
                '1 : w_sum[WIDTH-1:0];
      end
      w_dn: begin
        w_ovf = w_dif[WIDTH];
        w_led = (w_dif[WIDTH] && MODE == 1) ?
                '0 : w_dif[WIDTH-1:0];
      end
      default: begin
        w_led = r_led;
        w_ovf = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_led <= LP_RST;
      r_ovf <= 1'b0;
    end else begin
      r_led <= w_led;
      r_ovf <= w_ovf;
    end
  end

  assign led      = r_led;
  assign overflow = r_ovf;

endmodule

// File: tb/tb_button_updown_counter.sv
// Bench for button_updown_counter: wrap and saturate instances side by side,
// directed cases plus random button traffic against a run-length model.
module tb_button_updown_counter;

  localparam int D    = 4;
  localparam int HOLD = 8;
  localparam int REP  = 4;
  localparam int MAXV = 255;

  logic       clk;
  logic       reset;
  logic       east;
  logic       west;
  logic [7:0] led0;
  logic       ovf0;
  logic [7:0] led1;
  logic       ovf1;

  int n_cmp = 0;
  int n_bad = 0;

  button_updown_counter #(
    .WIDTH (8), .STEP (1), .MODE (0), .DEBOUNCE_CYCLES (D),
    .RESET_VALUE (0), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP)
  ) u_wrap (
    .clk (clk), .reset (reset), .east (east), .west (west),
    .led (led0), .overflow (ovf0)
  );

  button_updown_counter #(
    .WIDTH (8), .STEP (1), .MODE (1), .DEBOUNCE_CYCLES (D),
    .RESET_VALUE (0), .HOLD_CYCLES (HOLD), .REPEAT_CYCLES (REP)
  ) u_sat (
    .clk (clk), .reset (reset), .east (east), .west (west),
    .led (led1), .overflow (ovf1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: pins pass two sample delays, then a level flips
  // once D consecutive samples disagree with it.
  int m1 [2];
  int m2 [2];
  int lvl [2];
  int pend [2];
  int rise [2];
  bit req [2];
  bit reqp [2];
  int cyc;
  int exp_led0, exp_led1;
  int exp_ovf0, exp_ovf1;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < 2; b++) begin
        m1[b] = 0; m2[b] = 0; lvl[b] = 0; pend[b] = 0;
        req[b] = 0; reqp[b] = 0; rise[b] = 0;
      end
      exp_led0 = 0; exp_led1 = 0; exp_ovf0 = 0; exp_ovf1 = 0;
    end else begin
      int s, e, v;
      bit drop;
      cyc++;
      exp_ovf0 = 0;
      exp_ovf1 = 0;
      if (reqp[0] && !reqp[1]) begin
        v = exp_led0 + 1;
        exp_ovf0 = (v > MAXV);
        exp_led0 = v % (MAXV + 1);
        v = exp_led1 + 1;
        exp_ovf1 = (v > MAXV);
        exp_led1 = (v > MAXV) ? MAXV : v;
      end else if (reqp[1] && !reqp[0]) begin
        v = exp_led0 - 1;
        exp_ovf0 = (v < 0);
        exp_led0 = (v < 0) ? v + MAXV + 1 : v;
        v = exp_led1 - 1;
        exp_ovf1 = (v < 0);
        exp_led1 = (v < 0) ? 0 : v;
      end
      for (int b = 0; b < 2; b++) begin
        s = m2[b];
        m2[b] = m1[b];
        m1[b] = (b == 0) ? int'(east) : int'(west);
        req[b] = 0;
        drop = (pend[b] == D) && (lvl[b] == 1);
`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
        if (lvl[b] == 1 && !drop) begin
          e = cyc - rise[b];
          if (e == HOLD || (e > HOLD && (e - HOLD) % REP == 0))
            req[b] = 1;
        end
`else
        e = drop ? 1 : 0;
`endif
        if (pend[b] == D) begin
          lvl[b] = 1 - lvl[b];
          pend[b] = 0;
          if (lvl[b] == 1) begin
            req[b] = 1;
            rise[b] = cyc;
          end
        end else if (s != lvl[b]) begin
          pend[b]++;
        end else begin
          pend[b] = 0;
        end
      end
      reqp[0] = req[0];
      reqp[1] = req[1];
    end
  end

  always @(posedge clk) begin
    #2;
    check("wrap_led", led0, exp_led0);
    check("wrap_ovf", ovf0, exp_ovf0);
    check("sat_led", led1, exp_led1);
    check("sat_ovf", ovf1, exp_ovf1);
  end

  task automatic waitn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    waitn(2);
    reset = 1'b0;
  endtask

  initial begin
    east  = 1'b0;
    west  = 1'b0;
    reset = 1'b1;
    #3;
    check("rst_led", led0, 0);
    check("rst_ovf", ovf0, 0);
    waitn(3);
    reset = 1'b0;
    waitn(2);

    // Case 1: single press held 20 cycles.
    east = 1'b1;
    waitn(7);
    check("c1_edge6", led0, 0);
    waitn(1);
    check("c1_edge7", led0, 1);
    check("c1_ovf", ovf0, 0);
    waitn(12);
    east = 1'b0;
    waitn(20);
`ifdef BUTTON_COUNTER_AUTO_REPEAT_EN
    check("c1_final", led0, 4);
`else
    check("c1_final", led0, 1);
`endif

    // Case 2: underflow from zero.
    do_reset();
    west = 1'b1;
    waitn(8);
    check("c2_wrap_led", led0, 255);
    check("c2_wrap_ovf", ovf0, 1);
    check("c2_sat_led", led1, 0);
    check("c2_sat_ovf", ovf1, 1);
    waitn(1);
    check("c2_ovf_gone", ovf0, 0);
    west = 1'b0;
    waitn(15);

    // Case 3: glitch filter.
    do_reset();
    east = 1'b1;
    waitn(3);
    east = 1'b0;
    waitn(15);
    check("c3_short", led0, 0);
    east = 1'b1;
    waitn(4);
    east = 1'b0;
    waitn(15);
    check("c3_exact", led0, 1);
    for (int i = 0; i < 10; i++) begin
      west = ~west;
      waitn(1);
    end
    west = 1'b0;
    waitn(15);
    check("c3_bounce", led0, 1);

    // Case 4: simultaneity.
    do_reset();
    east = 1'b1;
    west = 1'b1;
    waitn(6);
    east = 1'b0;
    west = 1'b0;
    waitn(15);
    check("c4_same", led0, 0);
    east = 1'b1;
    waitn(1);
    west = 1'b1;
    waitn(7);
    check("c4_edge7", led0, 1);
    waitn(1);
    check("c4_edge8", led0, 0);
    east = 1'b0;
    west = 1'b0;
    waitn(25);

    // Case 5: reset in the middle of a press.
    do_reset();
    east = 1'b1;
    waitn(6);
    east = 1'b0;
    waitn(15);
    check("c5_pre", led0, 1);
    east = 1'b1;
    waitn(5);
    reset = 1'b1;
    #1;
    check("c5_async_wrap", led0, 0);
    check("c5_async_sat", led1, 0);
    @(negedge clk);
    reset = 1'b0;
    waitn(7);
    check("c5_edge6", led0, 0);
    waitn(1);
    check("c5_edge7", led0, 1);
    east = 1'b0;
    waitn(20);
    check("c5_once", led0, 1);

    // Random traffic; model compared every cycle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 5) == 0) east = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 5) == 0) west = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 699) == 0) begin
        reset = 1'b1;
        waitn($urandom_range(1, 2));
        reset = 1'b0;
      end
    end
    east = 1'b0;
    west = 1'b0;
    waitn(30);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
